iob_ram_sp_be_pipe: RTL and testbench

Single-port synchronous RAM, next generation of the team's basic SP RAM, generalised to byte-lane write enables, configurable read latency (1 or 2 cycles) with a read-valid pipeline, selectable read-during-write mode, and a hardware clear sequencer that zero-fills the whole array. Used as tag/data store in cache and accelerator buffers where software-initiated invalidation and timing-closure output registers are needed.

---
 rtl/iob_ram_sp_be_pipe_pkg.sv | 20 ++
 rtl/iob_ram_sp_be_pipe_if.sv | 26 ++
 rtl/iob_ram_sp_be_pipe_array.sv | 53 +++++
 rtl/iob_ram_sp_be_pipe.sv | 162 ++++++++++++++++
 tb/tb_iob_ram_sp_be_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_ram_sp_be_pipe_pkg.sv
// Shared constants for the byte-enabled pipelined SP RAM.
// Parameter defaults, clear FSM encodings, read-during-write modes.
package iob_ram_sp_be_pipe_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_RD_LAT   = 1;
   localparam int DEF_RDW_MODE = 0;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam int RDW_RF = 0;
   localparam int RDW_WF = 1;

   function automatic logic par8(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/iob_ram_sp_be_pipe_if.sv
// Access/clear bus of the SP RAM.
// master drives en/we/addr/d/clr; slave returns d_o/rvalid/busy/perr.
interface iob_ram_sp_be_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic                  en_i;
   logic [DATA_W/8-1:0]   we_i;
   logic [ADDR_W-1:0]     addr_i;
   logic [DATA_W-1:0]     d_i;
   logic                  clr_i;
   logic [DATA_W-1:0]     d_o;
   logic                  rvalid_o;
   logic                  busy_o;
   logic                  perr_o;

   modport master (
      output en_i, we_i, addr_i, d_i, clr_i,
      input  d_o, rvalid_o, busy_o, perr_o
   );

   modport slave (
      input  en_i, we_i, addr_i, d_i, clr_i,
      output d_o, rvalid_o, busy_o, perr_o
   );
endinterface

// File: rtl/iob_ram_sp_be_pipe_array.sv
// Raw lane-enabled storage with registered read port and RDW select.
// Ports: clk_i, rst_i, i_en, i_rd (capture read), i_we, i_addr, i_d, o_q.
module iob_ram_sp_be_pipe_array
   import iob_ram_sp_be_pipe_pkg::*;
#(
   parameter int NB       = 4,
   parameter int LANE_W   = 8,
   parameter int ADDR_W   = 10,
   parameter int RDW_MODE = DEF_RDW_MODE
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 i_en,
   input  logic                 i_rd,
   input  logic [NB-1:0]        i_we,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic [NB*LANE_W-1:0] i_d,
   output logic [NB*LANE_W-1:0] o_q
);
   localparam int W = NB * LANE_W;

   logic [W-1:0] r_mem [2**ADDR_W];
   logic [W-1:0] r_q;
   logic [W-1:0] w_old;
   logic [W-1:0] w_mrg;

   always_comb begin
      w_old = r_mem[i_addr];
      w_mrg = w_old;
      for (int i = 0; i < NB; i++)
         if (i_we[i])
            w_mrg[i*LANE_W +: LANE_W] = i_d[i*LANE_W +: LANE_W];
   end

   always_ff @(posedge clk_i) begin
      if (i_en)
         for (int i = 0; i < NB; i++)
            if (i_we[i])
               r_mem[i_addr][i*LANE_W +: LANE_W] <=
                  i_d[i*LANE_W +: LANE_W];
   end

   // Output only moves on user accesses so it holds between reads.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_q <= '0;
      else if (i_rd)
         r_q <= (RDW_MODE == RDW_WF) ? w_mrg : w_old;
   end

   assign o_q = r_q;

endmodule

// File: rtl/iob_ram_sp_be_pipe.sv
// Byte-enabled SP RAM: clear FSM, read-valid pipeline, output register.
// Ports: clk_i, rst_i, bus (slave). Macro: IOB_RAM_SP_BE_PIPE_PARITY_EN.
module iob_ram_sp_be_pipe
   import iob_ram_sp_be_pipe_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int RD_LAT   = DEF_RD_LAT,
   parameter int RDW_MODE = DEF_RDW_MODE,
   parameter     HEXFILE  = "none"
) (
   input  logic clk_i,
   input  logic rst_i,
   iob_ram_sp_be_pipe_if.slave bus
);
   localparam int NB = DATA_W / 8;
`ifdef IOB_RAM_SP_BE_PIPE_PARITY_EN
   localparam int LANE_W = 9;
`else
   localparam int LANE_W = 8;
`endif
   localparam int W = NB * LANE_W;

   logic [0:0]        r_state;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   w_cnt_nxt;
   logic              w_busy;
   logic              w_acc;
   logic              w_a_en;
   logic [NB-1:0]     w_a_we;
   logic [ADDR_W-1:0] w_a_addr;
   logic [W-1:0]      w_a_d;
   logic [W-1:0]      w_wr;
   logic [W-1:0]      w_q;
   logic [DATA_W-1:0] w_q_data;
   logic              w_perr_raw;
   logic              r_v1;
   logic [DATA_W-1:0] w_dout;
   logic              w_vld;
   logic              w_perr;

   assign w_busy    = (r_state == ST_CLEAR);
   assign w_acc     = bus.en_i & ~w_busy & ~rst_i;
   assign w_cnt_nxt = r_cnt + 1'b1;

   // Clear starts the cycle after clr_i, so a same-cycle user
   // access never collides with a clear write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (bus.clr_i) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_cnt <= w_cnt_nxt;
               if (w_cnt_nxt[ADDR_W])
                  r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_wr = '0;
      for (int i = 0; i < NB; i++) begin
         w_wr[i*LANE_W +: 8] = bus.d_i[i*8 +: 8];
`ifdef IOB_RAM_SP_BE_PIPE_PARITY_EN
         w_wr[i*LANE_W+8] = par8(bus.d_i[i*8 +: 8]);
`endif
      end
   end

   assign w_a_en   = (w_acc | w_busy) & ~rst_i;
   assign w_a_we   = w_busy ? '1 : bus.we_i;
   assign w_a_addr = w_busy ? r_cnt[ADDR_W-1:0] : bus.addr_i;
   assign w_a_d    = w_busy ? '0 : w_wr;

   iob_ram_sp_be_pipe_array #(
      .NB       (NB),
      .LANE_W   (LANE_W),
      .ADDR_W   (ADDR_W),
      .RDW_MODE (RDW_MODE)
   ) u_arr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_en   (w_a_en),
      .i_rd   (w_acc),
      .i_we   (w_a_we),
      .i_addr (w_a_addr),
      .i_d    (w_a_d),
      .o_q    (w_q)
   );

   always_comb begin
      w_q_data = '0;
      for (int i = 0; i < NB; i++)
         w_q_data[i*8 +: 8] = w_q[i*LANE_W +: 8];
   end

`ifdef IOB_RAM_SP_BE_PIPE_PARITY_EN
   // Even parity: each 9-bit lane must XOR to zero.
   always_comb begin
      w_perr_raw = 1'b0;
      for (int i = 0; i < NB; i++)
         w_perr_raw = w_perr_raw | (^w_q[i*LANE_W +: LANE_W]);
   end
`else
   assign w_perr_raw = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_v1 <= 1'b0;
      else
         r_v1 <= w_acc;
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              r_v2;
         logic              r_pe2;
         logic [DATA_W-1:0] r_d2;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_v2  <= 1'b0;
               r_pe2 <= 1'b0;
               r_d2  <= '0;
            end else begin
               r_v2  <= r_v1;
               r_pe2 <= r_v1 & w_perr_raw;
               if (r_v1)
                  r_d2 <= w_q_data;
            end
         end

         assign w_dout = r_d2;
         assign w_vld  = r_v2;
         assign w_perr = r_pe2;
      end else begin : g_lat1
         assign w_dout = w_q_data;
         assign w_vld  = r_v1;
         assign w_perr = r_v1 & w_perr_raw;
      end
   endgenerate

   assign bus.d_o      = w_dout;
   assign bus.rvalid_o = w_vld;
   assign bus.busy_o   = w_busy;
`ifdef IOB_RAM_SP_BE_PIPE_PARITY_EN
   assign bus.perr_o   = w_perr;
`else
   assign bus.perr_o   = 1'b0 & w_perr;
`endif

endmodule

// File: tb/tb_iob_ram_sp_be_pipe.sv
// Directed bench: dut_a (RD_LAT=1, read-first), dut_b (RD_LAT=2,
// write-first), both ADDR_W=4, driven with identical stimulus.
module tb_iob_ram_sp_be_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  we = '0;
   logic [3:0]  addr = '0;
   logic [31:0] d = '0;
   logic        clr = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   iob_ram_sp_be_pipe_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
   iob_ram_sp_be_pipe_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

   assign bus_a.en_i = en;
   assign bus_a.we_i = we;
   assign bus_a.addr_i = addr;
   assign bus_a.d_i = d;
   assign bus_a.clr_i = clr;
   assign bus_b.en_i = en;
   assign bus_b.we_i = we;
   assign bus_b.addr_i = addr;
   assign bus_b.d_i = d;
   assign bus_b.clr_i = clr;

   iob_ram_sp_be_pipe #(
      .DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .HEXFILE("none")
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .bus(bus_a.slave)
   );

   iob_ram_sp_be_pipe #(
      .DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1), .HEXFILE("none")
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .bus(bus_b.slave)
   );

   // One access, then samples one and two edges after acceptance.
   task automatic do_access(
      input  logic [3:0]  w,
      input  logic [3:0]  a,
      input  logic [31:0] dat,
      output logic        va1,
      output logic [31:0] da1,
      output logic        pa1,
      output logic        vb1,
      output logic        va2,
      output logic [31:0] da2,
      output logic        vb2,
      output logic [31:0] db2,
      output logic        pb2
   );
      @(posedge clk); #1;
      en = 1'b1; we = w; addr = a; d = dat;
      @(posedge clk); #1;
      en = 1'b0; we = '0;
      va1 = bus_a.rvalid_o; da1 = bus_a.d_o;
      pa1 = bus_a.perr_o; vb1 = bus_b.rvalid_o;
      @(posedge clk); #1;
      va2 = bus_a.rvalid_o; da2 = bus_a.d_o;
      vb2 = bus_b.rvalid_o; db2 = bus_b.d_o;
      pb2 = bus_b.perr_o;
   endtask

   logic        va1, pa1, vb1, va2, vb2, pb2;
   logic [31:0] da1, da2, db2;

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_a.d_o !== 32'h0 || bus_b.d_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_d a=%h b=%h exp 0", bus_a.d_o, bus_b.d_o);
      end
      checks++;
      if ({bus_a.rvalid_o, bus_a.busy_o, bus_a.perr_o,
           bus_b.rvalid_o, bus_b.busy_o, bus_b.perr_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags a=%b%b%b b=%b%b%b exp 0",
            bus_a.rvalid_o, bus_a.busy_o, bus_a.perr_o,
            bus_b.rvalid_o, bus_b.busy_o, bus_b.perr_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      do_access(4'hF, 4'd5, 32'hDEADBEEF,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      checks++;
      if ({va1, vb1, va2, vb2} !== 4'b1001) begin
         errors++;
         $display("FAIL wr_latency got %b exp 1001", {va1, vb1, va2, vb2});
      end
      checks++;
      if (db2 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_wf_b got %h exp deadbeef", db2);
      end
      do_access(4'h0, 4'd5, 32'h0,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      checks++;
      if ({va1, vb1, va2, vb2} !== 4'b1001) begin
         errors++;
         $display("FAIL rd_latency got %b exp 1001", {va1, vb1, va2, vb2});
      end
      checks++;
      if (da1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd5_a got %h exp deadbeef", da1);
      end
      checks++;
      if (db2 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd5_b got %h exp deadbeef", db2);
      end
      checks++;
      if (da2 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL hold_a got %h exp deadbeef", da2);
      end
      checks++;
      if (pa1 !== 1'b0 || pb2 !== 1'b0) begin
         errors++;
         $display("FAIL perr_clean got %b%b exp 00", pa1, pb2);
      end
   endtask

   task automatic test_byte_en();
      do_access(4'hF, 4'd3, 32'h11223344,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      do_access(4'h2, 4'd3, 32'hAAAAAAAA,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      checks++;
      if (da1 !== 32'h11223344) begin
         errors++;
         $display("FAIL be_rf_a got %h exp 11223344", da1);
      end
      checks++;
      if (db2 !== 32'h1122AA44) begin
         errors++;
         $display("FAIL be_wf_b got %h exp 1122aa44", db2);
      end
      do_access(4'h0, 4'd3, 32'h0,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      checks++;
      if (da1 !== 32'h1122AA44 || db2 !== 32'h1122AA44) begin
         errors++;
         $display("FAIL be_rd a=%h b=%h exp 1122aa44", da1, db2);
      end
   endtask

   task automatic test_rdw();
      do_access(4'hF, 4'd7, 32'h1,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      do_access(4'hF, 4'd7, 32'h2,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      checks++;
      if (da1 !== 32'h1) begin
         errors++;
         $display("FAIL rdw_rf_a got %h exp 1", da1);
      end
      checks++;
      if (db2 !== 32'h2) begin
         errors++;
         $display("FAIL rdw_wf_b got %h exp 2", db2);
      end
   endtask

   task automatic fill(input logic [31:0] base);
      for (int i = 0; i < 16; i++)
         do_access(4'hF, 4'(i), base + 32'(i),
            va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
   endtask

   task automatic test_clear();
      int          bc, na, nb;
      logic [31:0] dva, dvb;
      fill(32'h100);
      bc = 0; na = 0; nb = 0; dva = '0; dvb = '0;
      @(posedge clk); #1;
      en = 1'b1; we = '0; addr = 4'd4; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (bus_a.busy_o) bc++;
         if (bus_a.rvalid_o) begin na++; dva = bus_a.d_o; end
         if (bus_b.rvalid_o) begin nb++; dvb = bus_b.d_o; end
         if (!bus_a.busy_o) break;
         @(posedge clk); #1;
      end
      en = 1'b0;
      checks++;
      if (bc != 16) begin
         errors++;
         $display("FAIL clr_busy_cycles got %0d exp 16", bc);
      end
      checks++;
      if (na != 1 || nb != 1) begin
         errors++;
         $display("FAIL clr_rvalid_cnt a=%0d b=%0d exp 1", na, nb);
      end
      checks++;
      if (dva !== 32'h104 || dvb !== 32'h104) begin
         errors++;
         $display("FAIL clr_same_cyc a=%h b=%h exp 104", dva, dvb);
      end
      for (int i = 0; i < 16; i++) begin
         do_access(4'h0, 4'(i), 32'h0,
            va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
         checks++;
         if (da1 !== 32'h0 || db2 !== 32'h0) begin
            errors++;
            $display("FAIL clr_zero[%0d] a=%h b=%h exp 0", i, da1, db2);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int nv;
      fill(32'h200);
      nv = 0;
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      checks++;
      if (bus_a.busy_o !== 1'b1) begin
         errors++;
         $display("FAIL rmc_busy_start got %b exp 1", bus_a.busy_o);
      end
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (bus_a.rvalid_o || bus_b.rvalid_o) nv++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if (bus_a.rvalid_o || bus_b.rvalid_o) nv++;
      checks++;
      if (bus_a.busy_o !== 1'b0 || bus_b.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rmc_busy a=%b b=%b exp 0",
            bus_a.busy_o, bus_b.busy_o);
      end
      checks++;
      if (nv != 0) begin
         errors++;
         $display("FAIL rmc_rvalid got %0d exp 0", nv);
      end
      for (int i = 0; i < 16; i++) begin
         logic [31:0] e;
         e = (i < 8) ? 32'h0 : 32'h200 + 32'(i);
         do_access(4'h0, 4'(i), 32'h0,
            va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
         checks++;
         if (da1 !== e || db2 !== e) begin
            errors++;
            $display("FAIL rmc_data[%0d] a=%h b=%h exp %h", i, da1, db2, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic        ea, eb;
      logic [31:0] xa, xb;
      @(posedge clk); #1;
      en = 1'b1; we = '0; addr = 4'd8;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         en = (i + 1 < 4);
         addr = 4'(9 + i);
         ea = (i < 4);
         eb = (i >= 1 && i <= 4);
         xa = 32'h208 + 32'(i);
         xb = 32'h208 + 32'(i - 1);
         checks++;
         if (bus_a.rvalid_o !== ea || bus_b.rvalid_o !== eb) begin
            errors++;
            $display("FAIL b2b_vld[%0d] a=%b b=%b exp %b %b",
               i, bus_a.rvalid_o, bus_b.rvalid_o, ea, eb);
         end
         if (ea) begin
            checks++;
            if (bus_a.d_o !== xa) begin
               errors++;
               $display("FAIL b2b_a[%0d] got %h exp %h", i, bus_a.d_o, xa);
            end
         end
         if (eb) begin
            checks++;
            if (bus_b.d_o !== xb) begin
               errors++;
               $display("FAIL b2b_b[%0d] got %h exp %h", i, bus_b.d_o, xb);
            end
         end
      end
      en = 1'b0;
   endtask

`ifdef IOB_RAM_SP_BE_PIPE_PARITY_EN
   task automatic test_parity();
      dut_a.u_arr.r_mem[2][0] = ~dut_a.u_arr.r_mem[2][0];
      do_access(4'h0, 4'd2, 32'h0,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      checks++;
      if (va1 !== 1'b1 || pa1 !== 1'b1 || da1 !== 32'h1) begin
         errors++;
         $display("FAIL par_err v=%b p=%b d=%h exp 1 1 1", va1, pa1, da1);
      end
      do_access(4'h0, 4'd9, 32'h0,
         va1, da1, pa1, vb1, va2, da2, vb2, db2, pb2);
      checks++;
      if (pa1 !== 1'b0 || pb2 !== 1'b0) begin
         errors++;
         $display("FAIL par_clean a=%b b=%b exp 0", pa1, pb2);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write_read();
      test_byte_en();
      test_rdw();
      test_clear();
      test_reset_mid_clear();
      test_back_to_back();
`ifdef IOB_RAM_SP_BE_PIPE_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors",
         checks, errors);
      $finish;
   end

endmodule
